// File: rtl/lcd_bus_arbiter.sv
// Two-port round-robin arbiter driving a character-LCD bus (E/RS/RW/DATA).
// Define LCD_ARB_INIT_EN to issue the power-up command sequence after reset.
module lcd_bus_arbiter #(
   parameter int INIT_DELAY = 70,
   parameter int T_SETUP    = 1,
   parameter int T_EH       = 2,
   parameter int T_HOLD     = 1,
   parameter int T_CMD      = 30,
   parameter int T_CLR      = 200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic       RS0,
   input  logic       RS1,
   input  logic [7:0] DATA0,
   input  logic [7:0] DATA1,
   output logic       ACK0,
   output logic       ACK1,
   output logic       BUSY,
   output logic       INIT_DONE,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);
   // state | meaning
   // PWRUP | post-reset wait; launches the init sequence when enabled
   // IDLE  | arbitrating between the two ports
   // SETUP | RS/DATA driven, E low
   // EHIGH | E high
   // HOLD  | E low, RS/DATA held
   // WAIT  | LCD execution time (long for clear/home)
   typedef enum logic [2:0] {PWRUP, IDLE, SETUP, EHIGH, HOLD, WAIT} state_t;

   localparam logic [15:0] C_INIT  = 16'(INIT_DELAY - 1);
   localparam logic [15:0] C_SETUP = 16'(T_SETUP - 1);
   localparam logic [15:0] C_EH    = 16'(T_EH - 1);
   localparam logic [15:0] C_HOLD  = 16'(T_HOLD - 1);
   localparam logic [15:0] C_CMD   = 16'(T_CMD - 1);
   localparam logic [15:0] C_CLR   = 16'(T_CLR - 1);

   state_t      state;
   logic [15:0] cnt;
   logic        gnt;
   logic        last;
   logic        elig0, elig1, pick1, is_clr;

`ifdef LCD_ARB_INIT_EN
   logic        init;
   logic [1:0]  init_idx;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction
`endif

   assign LCD_RW = 1'b0;

   // A port is ignored during its own ACK cycle so it cannot be re-granted on a stale request.
   always_comb begin
      elig0  = REQ0 && !ACK0;
      elig1  = REQ1 && !ACK1;
      pick1  = elig1 && (!elig0 || !last);
      is_clr = !LCD_RS && (LCD_DATA[7:2] == 6'd0);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= PWRUP;
         cnt       <= C_INIT;
         gnt       <= 1'b0;
         last      <= 1'b1;
         ACK0      <= 1'b0;
         ACK1      <= 1'b0;
         BUSY      <= 1'b1;
         INIT_DONE <= 1'b0;
         LCD_E     <= 1'b0;
         LCD_RS    <= 1'b0;
         LCD_DATA  <= 8'h00;
`ifdef LCD_ARB_INIT_EN
         init      <= 1'b0;
         init_idx  <= 2'd0;
`endif
      end else begin
         ACK0 <= 1'b0;
         ACK1 <= 1'b0;
         case (state)
            PWRUP: begin
`ifdef LCD_ARB_INIT_EN
               if (cnt != 16'd0) cnt <= cnt - 16'd1;
               else begin
                  init     <= 1'b1;
                  init_idx <= 2'd0;
                  LCD_RS   <= 1'b0;
                  LCD_DATA <= init_cmd(2'd0);
                  cnt      <= C_SETUP;
                  state    <= SETUP;
               end
`else
               BUSY      <= 1'b0;
               INIT_DONE <= 1'b1;
               state     <= IDLE;
`endif
            end
            IDLE: begin
               if (elig0 || elig1) begin
                  gnt      <= pick1;
                  last     <= pick1;
                  LCD_RS   <= pick1 ? RS1 : RS0;
                  LCD_DATA <= pick1 ? DATA1 : DATA0;
                  cnt      <= C_SETUP;
                  BUSY     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt != 16'd0) cnt <= cnt - 16'd1;
               else begin
                  LCD_E <= 1'b1;
                  cnt   <= C_EH;
                  state <= EHIGH;
               end
            end
            EHIGH: begin
               if (cnt != 16'd0) cnt <= cnt - 16'd1;
               else begin
                  LCD_E <= 1'b0;
                  cnt   <= C_HOLD;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (cnt != 16'd0) cnt <= cnt - 16'd1;
               else begin
                  cnt   <= is_clr ? C_CLR : C_CMD;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 16'd0) cnt <= cnt - 16'd1;
`ifdef LCD_ARB_INIT_EN
               else if (init && init_idx != 2'd3) begin
                  init_idx <= init_idx + 2'd1;
                  LCD_DATA <= init_cmd(init_idx + 2'd1);
                  cnt      <= C_SETUP;
                  state    <= SETUP;
               end else if (init) begin
                  init      <= 1'b0;
                  INIT_DONE <= 1'b1;
                  BUSY      <= 1'b0;
                  state     <= IDLE;
               end
`endif
               else begin
                  BUSY  <= 1'b0;
                  ACK0  <= !gnt;
                  ACK1  <= gnt;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter (default build, init sequence disabled):
// directed steps followed by random request traffic against a transaction-level model.
module tb_lcd_bus_arbiter;
   localparam int INIT_DELAY = 70;
   localparam int T_SETUP    = 1;
   localparam int T_EH       = 2;
   localparam int T_HOLD     = 1;
   localparam int T_CMD      = 30;
   localparam int T_CLR      = 200;

   logic       CLK, RESET, REQ0, REQ1, RS0, RS1;
   logic [7:0] DATA0, DATA1;
   logic       ACK0, ACK1, BUSY, INIT_DONE, LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA;

   int n_checks = 0;
   int n_err    = 0;
   int last_srv;
   int acked;
   logic       req  [2];
   logic       prs  [2];
   logic [7:0] pdat [2];

   lcd_bus_arbiter #(
      .INIT_DELAY(INIT_DELAY), .T_SETUP(T_SETUP), .T_EH(T_EH),
      .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(REQ0), .REQ1(REQ1), .RS0(RS0), .RS1(RS1),
      .DATA0(DATA0), .DATA1(DATA1),
      .ACK0(ACK0), .ACK1(ACK1), .BUSY(BUSY), .INIT_DONE(INIT_DONE),
      .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Execution wait: clear/home (command byte below 0x04) takes the long wait.
   function automatic int wait_len(input logic rs, input logic [7:0] d);
      return (rs == 1'b0 && d < 8'h04) ? T_CLR : T_CMD;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ports();
      REQ0 = req[0]; RS0 = prs[0]; DATA0 = pdat[0];
      REQ1 = req[1]; RS1 = prs[1]; DATA1 = pdat[1];
   endtask

   function automatic logic [7:0] rnd_data();
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 3));
      return 8'($urandom_range(0, 255));
   endfunction

   // Called at a negedge; the next posedge is the sampling edge where port w is granted.
   // ACK is expected on edge g+T_SETUP+T_EH+T_HOLD+T_WAIT, i.e. the (1+that)th edge
   // when the sampling edge itself is counted as the first. Returns at the ACK-cycle negedge.
   task automatic run_xfer(input int w, input logic rs, input logic [7:0] d,
                           input logic drop, input string tag);
      int dur, first_e, e_cnt, ack_j, unstable, busy_low;
      logic [7:0] e_data;
      logic       e_rs;
      dur = T_SETUP + T_EH + T_HOLD + wait_len(rs, d);
      first_e = -1; e_cnt = 0; ack_j = -1; unstable = 0; busy_low = 0;
      e_data = 8'h00; e_rs = 1'b0;
      @(posedge CLK);
      for (int j = 0; j <= dur + 8; j++) begin
         @(negedge CLK);
         if (j == 0 && drop) begin
            req[w] = 1'b0; prs[w] = ~prs[w]; pdat[w] = ~pdat[w];
            drive_ports();
         end
         if (ACK0 || ACK1) begin
            ack_j = j;
            break;
         end
         if (LCD_E) begin
            if (first_e < 0) first_e = j;
            e_cnt++;
            e_data = LCD_DATA;
            e_rs = LCD_RS;
         end
         if (LCD_RS !== rs || LCD_DATA !== d || LCD_RW !== 1'b0) unstable++;
         if (BUSY !== 1'b1) busy_low++;
      end
      chk({tag, "_e_start"}, first_e, T_SETUP);
      chk({tag, "_e_len"}, e_cnt, T_EH);
      chk({tag, "_e_data"}, e_data, d);
      chk({tag, "_e_rs"}, e_rs, rs);
      chk({tag, "_bus_stable"}, unstable, 0);
      chk({tag, "_busy_low"}, busy_low, 0);
      chk({tag, "_ack_at"}, ack_j, dur);
      chk({tag, "_ack_pair"}, {ACK1, ACK0}, (w == 1) ? 2'b10 : 2'b01);
      chk({tag, "_ack_busy"}, BUSY, 1'b0);
      chk({tag, "_idle_e"}, LCD_E, 1'b0);
      chk({tag, "_idle_data"}, {LCD_RS, LCD_DATA}, {rs, d});
   endtask

   task automatic idle_check(input int n, input string tag);
      int acks, es, busies;
      acks = 0; es = 0; busies = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (ACK0 || ACK1) acks++;
         if (LCD_E) es++;
         if (BUSY !== 1'b0) busies++;
      end
      chk({tag, "_ack"}, acks, 0);
      chk({tag, "_e"}, es, 0);
      chk({tag, "_busy"}, busies, 0);
   endtask

   initial begin
      logic el0, el1;
      int   w;
      logic drop;
      RESET = 1'b1;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; prs[p] = 1'b0; pdat[p] = 8'h00;
      end
      drive_ports();
      repeat (3) @(negedge CLK);

      // Reset values
      chk("rst_e", LCD_E, 1'b0);
      chk("rst_rs", LCD_RS, 1'b0);
      chk("rst_rw", LCD_RW, 1'b0);
      chk("rst_data", LCD_DATA, 8'h00);
      chk("rst_ack", {ACK1, ACK0}, 2'b00);
      chk("rst_busy", BUSY, 1'b1);
      chk("rst_init_done", INIT_DONE, 1'b0);
      RESET = 1'b0;
      @(negedge CLK);
      chk("rel_init_done", INIT_DONE, 1'b1);
      chk("rel_busy", BUSY, 1'b0);

      // Both ports held: port 0 first after reset, then strict alternation, no gap.
      req[0] = 1'b1; prs[0] = 1'b1; pdat[0] = 8'h41;
      req[1] = 1'b1; prs[1] = 1'b1; pdat[1] = 8'h42;
      drive_ports();
      run_xfer(0, 1'b1, 8'h41, 1'b0, "rr0");
      run_xfer(1, 1'b1, 8'h42, 1'b0, "rr1");
      run_xfer(0, 1'b1, 8'h41, 1'b0, "rr2");
      run_xfer(1, 1'b1, 8'h42, 1'b0, "rr3");
      req[0] = 1'b0; req[1] = 1'b0;
      drive_ports();
      idle_check(3, "idle_a");

      // Single port 0 character write, then port 1 clear (long wait).
      req[0] = 1'b1; prs[0] = 1'b1; pdat[0] = 8'h41;
      drive_ports();
      run_xfer(0, 1'b1, 8'h41, 1'b0, "single0");
      req[0] = 1'b0; req[1] = 1'b1; prs[1] = 1'b0; pdat[1] = 8'h01;
      drive_ports();
      run_xfer(1, 1'b0, 8'h01, 1'b0, "clr1");
      req[1] = 1'b0;
      drive_ports();
      idle_check(2, "idle_b");
      // Port 1 again (single requester despite being last served); drops REQ mid-transfer.
      req[1] = 1'b1; prs[1] = 1'b0; pdat[1] = 8'h80;
      drive_ports();
      run_xfer(1, 1'b0, 8'h80, 1'b1, "cmd80");

      // Reset during EHIGH aborts with no ACK.
      req[0] = 1'b1; prs[0] = 1'b1; pdat[0] = 8'h55;
      drive_ports();
      @(posedge CLK);
      repeat (T_SETUP + 1) @(negedge CLK);
      chk("abort_pre_e", LCD_E, 1'b1);
      RESET = 1'b1;
      req[0] = 1'b0;
      drive_ports();
      #1;
      chk("abort_e", LCD_E, 1'b0);
      chk("abort_busy", BUSY, 1'b1);
      chk("abort_ack", {ACK1, ACK0}, 2'b00);
      chk("abort_bus", {LCD_RS, LCD_DATA}, 9'h000);
      chk("abort_init_done", INIT_DONE, 1'b0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      idle_check(40, "post_abort");

      // After reset, port 0 has priority again.
      req[0] = 1'b1; prs[0] = 1'b1; pdat[0] = 8'h5A;
      req[1] = 1'b1; prs[1] = 1'b0; pdat[1] = 8'h80;
      drive_ports();
      run_xfer(0, 1'b1, 8'h5A, 1'b0, "post0");
      run_xfer(1, 1'b0, 8'h80, 1'b0, "post1");
      req[0] = 1'b0; req[1] = 1'b0;
      drive_ports();
      last_srv = 1;
      acked = 1;

      // Random traffic; model: round-robin on eligible ports, ACKed port excluded in its ACK cycle.
      for (int it = 0; it < 30; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (p == acked || !req[p]) begin
               req[p] = ($urandom_range(0, 99) < 55);
               prs[p] = 1'($urandom_range(0, 1));
               pdat[p] = rnd_data();
            end
         end
         if (!req[0] && !req[1]) begin
            w = int'($urandom_range(0, 1));
            req[w] = 1'b1; prs[w] = 1'($urandom_range(0, 1)); pdat[w] = rnd_data();
         end
         drive_ports();
         el0 = req[0] && acked != 0;
         el1 = req[1] && acked != 1;
         if (!el0 && !el1) begin
            @(negedge CLK);
            chk("rnd_gap_ack", {ACK1, ACK0}, 2'b00);
            chk("rnd_gap_busy", BUSY, 1'b0);
            el0 = req[0];
            el1 = req[1];
         end
         w = (el0 && el1) ? 1 - last_srv : (el1 ? 1 : 0);
         drop = ($urandom_range(0, 3) == 0);
         run_xfer(w, prs[w], pdat[w], drop, "rnd");
         last_srv = w;
         acked = w;
      end

      req[0] = 1'b0; req[1] = 1'b0;
      drive_ports();
      @(negedge CLK);
      chk("final_ack_single", {ACK1, ACK0}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
